atom_decimator_10x: RTL

Decimating FIR atom, the receive-side counterpart of the 10x interpolator atoms. It takes signed 8-bit samples at the 10x rate (one per clk_en_10x) and keeps a TAPS-deep history. On each base-rate clk_en it computes one filtered, rounded and saturated output sample with a sequential multiply-accumulate. It sits between the 10x-rate front end and the base-rate sample path, and uses the same phase-aligned clk_en / clk_en_10x strobes as the interpolator chain.

---
 rtl/gf_filter_pkg.sv | 48 ++++
 rtl/atom_decimator_mac.sv | 47 ++++
 rtl/atom_decimator_10x.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gf_filter_pkg.sv
// Shared definitions for the 10x filter atoms: coefficient tables, rounding
// constants, accumulator sizing and FSM state encoding.
package gf_filter_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int ROUND_CONST = 64;
    localparam int ROUND_SHIFT = 7;
    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Sized so that TAPS full-scale products can never overflow the accumulator.
    function automatic int acc_width(input int coef_w, input int taps);
        return SAMPLE_W + coef_w + $clog2(taps);
    endfunction

    // Set 1 holds 128 in tap 0, which needs COEF_W >= 9 to stay positive.
    function automatic int coef(input int set, input int i);
        int c;
        c = 0;
        case (set)
            1: c = (i == 0) ? 128 : 0;
            2: c = 6;
            3: c = 8;
            default: begin
                case (i)
                    1, 18:   c = 1;
                    2, 17:   c = 2;
                    3, 16:   c = 3;
                    4, 15:   c = 5;
                    5, 14:   c = 7;
                    6, 13:   c = 9;
                    7, 12:   c = 11;
                    8, 11:   c = 12;
                    9, 10:   c = 14;
                    default: c = 0;
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/atom_decimator_mac.sv
// Multiply-accumulate datapath for the decimator: one signed product per enabled
// cycle, with round-half-up and saturation to 8 bits on the output.
module atom_decimator_mac
    import gf_filter_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [7:0]        a,
    input  logic [COEF_W-1:0] b,
    output logic [7:0]        y
);

    logic signed [SAMPLE_W+COEF_W-1:0] product;
    logic signed [ACC_W-1:0]           acc_reg;
    logic signed [ACC_W-1:0]           rounded;
    logic signed [ACC_W-1:0]           shifted;

    assign product = $signed(a) * $signed(b);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + ACC_W'(product);
        end
    end

    assign rounded = acc_reg + $signed(ACC_W'(ROUND_CONST));
    assign shifted = rounded >>> ROUND_SHIFT;

    always_comb begin
        y = shifted[7:0];
        if (shifted > $signed(ACC_W'(SAT_MAX))) begin
            y = 8'h7f;
        end else if (shifted < $signed(ACC_W'(SAT_MIN))) begin
            y = 8'h80;
        end
    end

endmodule

// File: rtl/atom_decimator_10x.sv
// Decimating FIR: keeps a 10x-rate sample history, snapshots it on each base-rate
// strobe and runs one tap per clock through the MAC to produce one output sample.
module atom_decimator_10x
    import gf_filter_pkg::*;
#(
    parameter int TAPS     = 20,
    parameter int COEF_W   = 8,
    parameter int COEF_SET = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en_10x,
    input  logic       clk_en,
    input  logic [7:0] sample_x,
    output logic [7:0] sample_y,
    output logic       y_valid,
    output logic       overrun
);

    localparam int ACC_W = acc_width(COEF_W, TAPS);
    localparam int IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    logic [1:0]               state_reg;
    logic [IDX_W-1:0]         idx_reg;
    // The window's oldest tap comes from hist_reg[TAPS-2]; the newest is sample_x itself.
    logic [7:0]               hist_reg [TAPS-1];
    logic [7:0]               snap_reg [TAPS];
    logic signed [COEF_W-1:0] coef_rom [TAPS];
    logic [7:0]               sample_y_reg;
    logic                     y_valid_reg;
    logic                     overrun_reg;

    logic                     snap_load;
    logic                     mac_en;
    logic [7:0]               mac_a;
    logic [COEF_W-1:0]        mac_b;
    logic [7:0]               mac_y;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_coef
            assign coef_rom[gi] = COEF_W'(coef(COEF_SET, gi));
        end
    endgenerate

    assign snap_load = clk_en && (state_reg == ST_IDLE);
    assign mac_en    = (state_reg == ST_MAC);
    assign mac_a     = snap_reg[idx_reg];
    assign mac_b     = coef_rom[idx_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                hist_reg[k] <= '0;
            end
        end else if (clk_en_10x) begin
            hist_reg[0] <= sample_x;
            for (int k = 1; k < TAPS - 1; k++) begin
                hist_reg[k] <= hist_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                snap_reg[k] <= '0;
            end
        end else if (snap_load) begin
            snap_reg[0] <= sample_x;
            for (int k = 1; k < TAPS; k++) begin
                snap_reg[k] <= hist_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            sample_y_reg <= '0;
            y_valid_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            y_valid_reg <= 1'b0;
            // A strobe outside IDLE is dropped; the running window finishes untouched.
            if (clk_en && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (clk_en) begin
                        idx_reg   <= '0;
                        state_reg <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    sample_y_reg <= mac_y;
                    y_valid_reg  <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    atom_decimator_mac #(
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (snap_load),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .y     (mac_y)
    );

    assign sample_y = sample_y_reg;
    assign y_valid  = y_valid_reg;
    assign overrun  = overrun_reg;

endmodule
